// File: rtl/wfg_spi_arbiter_pkg.sv
// Shared types and default sizes for the wfg SPI arbiter.
package wfg_spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    GAP
  } state_t;

  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_GAP_W   = 8;
  localparam int DEF_TO_W    = 16;

endpackage

// File: rtl/wfg_spi_arbiter_if.sv
// Requester, driver and control signals of the arbiter; slave = arbiter side, master = environment.
interface wfg_spi_arbiter_if
  import wfg_spi_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int GAP_W   = DEF_GAP_W
);
  logic                      en_i;
  logic [GAP_W-1:0]          gap_cycles_i;
  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ*DATA_W-1:0] req_data_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [NUM_REQ-1:0]        grant_o;
  logic                      spi_valid_o;
  logic [DATA_W-1:0]         spi_data_o;
  logic                      spi_ready_i;
  logic                      spi_done_i;
  logic                      busy_o;
  logic                      timeout_o;

  modport slave (
    input  en_i, gap_cycles_i, req_valid_i, req_data_i, spi_ready_i, spi_done_i,
    output req_ready_o, grant_o, spi_valid_o, spi_data_o, busy_o, timeout_o
  );

  modport master (
    output en_i, gap_cycles_i, req_valid_i, req_data_i, spi_ready_i, spi_done_i,
    input  req_ready_o, grant_o, spi_valid_o, spi_data_o, busy_o, timeout_o
  );
endinterface

// File: rtl/wfg_spi_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req scanning upward from ptr+1 with wrap.
module wfg_rr_pick
  import wfg_spi_arb_pkg::*;
#(
  parameter int N     = DEF_NUM_REQ,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] index,
  output logic             any
);
  always_comb begin
    int idx;
    logic [PTR_W-1:0] sel;
    grant = '0;
    index = '0;
    any   = 1'b0;
    idx   = 0;
    sel   = '0;
    // k = N lands back on ptr itself, so a lone requester can win again
    for (int k = 1; k <= N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      sel = idx[PTR_W-1:0];
      if (!any && req[sel]) begin
        any        = 1'b1;
        grant[sel] = 1'b1;
        index      = sel;
      end
    end
  end
endmodule

// File: rtl/wfg_spi_arbiter.sv
// Round-robin share of one SPI driver: grant latches a word (spi_valid_o next cycle), held until frame done + gap.
// Driver backpressure holds spi_valid_o/spi_data_o; define WFG_SPI_ARB_TIMEOUT_EN for the done-timeout.
module wfg_spi_arbiter
  import wfg_spi_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int GAP_W   = DEF_GAP_W,
  parameter int TO_W    = DEF_TO_W
) (
  input logic              wb_clk_i,
  input logic              wb_rst_i,
  wfg_spi_arbiter_if.slave bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, pick_idx;
  logic [NUM_REQ-1:0] pick_oh, grant_q, ready_d;
  logic               pick_any, grant_now, frame_end, load_gap, clr_grant, to_fire;
  logic [DATA_W-1:0]  data_q;
  logic [GAP_W-1:0]   gap_q;

  wfg_rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_pick (
    .req   (bus.req_valid_i),
    .ptr   (ptr_q),
    .grant (pick_oh),
    .index (pick_idx),
    .any   (pick_any)
  );

  // Gated by reset so no requester sees a take while the arbiter is being cleared
  assign grant_now = (state_q == IDLE) && bus.en_i && pick_any && !wb_rst_i;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    ready_d   = '0;
    frame_end = 1'b0;
    load_gap  = 1'b0;
    clr_grant = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_now) begin
          ready_d = pick_oh;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.spi_ready_i) begin
          if (bus.spi_done_i) frame_end = 1'b1;
          else                state_d   = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (bus.spi_done_i || to_fire) frame_end = 1'b1;
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d   = IDLE;
          clr_grant = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (frame_end) begin
      if (bus.gap_cycles_i == '0) begin
        state_d   = IDLE;
        clr_grant = 1'b1;
      end else begin
        state_d  = GAP;
        load_gap = 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ptr_q   <= PTR_W'(NUM_REQ - 1);
      grant_q <= '0;
      data_q  <= '0;
      gap_q   <= '0;
    end else begin
      if (grant_now) begin
        ptr_q   <= pick_idx;
        grant_q <= pick_oh;
        data_q  <= bus.req_data_i[int'(pick_idx)*DATA_W +: DATA_W];
      end else if (clr_grant) begin
        grant_q <= '0;
      end
      // Loaded with gap-1 so GAP lasts exactly gap_cycles_i cycles
      if (load_gap)
        gap_q <= bus.gap_cycles_i - GAP_W'(1);
      else if (state_q == GAP && gap_q != '0)
        gap_q <= gap_q - GAP_W'(1);
    end
  end

`ifdef WFG_SPI_ARB_TIMEOUT_EN
  logic [TO_W-1:0] to_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || state_q != WAIT_DONE) to_q <= '0;
    else                                  to_q <= to_q + TO_W'(1);
  end

  assign to_fire = (state_q == WAIT_DONE) && !bus.spi_done_i && (to_q == {TO_W{1'b1}});
`else
  logic [TO_W-1:0] unused_to_cnt;
  assign unused_to_cnt = '0;
  assign to_fire       = 1'b0;
`endif

  assign bus.req_ready_o = ready_d;
  assign bus.grant_o     = grant_q;
  assign bus.spi_valid_o = (state_q == ISSUE);
  assign bus.spi_data_o  = data_q;
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.timeout_o   = to_fire;
endmodule
